// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches one at a time and buffers
// returned instructions in a DEPTH-entry circular queue; flush redirects the fetch pointer.
module instruction_prefetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_mem_req,
  output logic [31:0]              o_mem_addr,
  input  logic [31:0]              i_mem_rdata,
  input  logic                     i_mem_rvalid,
  output logic [31:0]              o_instr,
  output logic [31:0]              o_instr_addr,
  output logic                     o_instr_valid,
  input  logic                     i_instr_ready,
  input  logic                     i_flush,
  input  logic [31:0]              i_flush_addr,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_fpc;
  logic [31:0]        r_req_addr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_data_q [DEPTH];
  logic [31:0]        r_addr_q [DEPTH];

  logic w_full;
  logic w_issue;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == CNT_W'(DEPTH));
  // Reset gating keeps the request low while the block is held in reset.
  assign w_issue = i_rst_n && (r_state == IDLE) && !i_flush && !w_full;
  assign w_push  = (r_state == WAIT) && i_mem_rvalid && !i_flush;
  assign w_pop   = o_instr_valid && i_instr_ready && !i_flush;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_issue) w_state_next = WAIT;
      end
      WAIT: begin
        if (i_mem_rvalid)  w_state_next = IDLE;
        else if (i_flush)  w_state_next = DROP;
      end
      DROP: begin
        if (i_mem_rvalid) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_fpc      <= RESET_ADDR;
      r_req_addr <= RESET_ADDR;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_flush) begin
        r_fpc    <= i_flush_addr;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_issue) begin
          r_fpc      <= r_fpc + 32'd1;
          r_req_addr <= r_fpc;
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage is reset so the head outputs read as zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data_q[i] <= '0;
        r_addr_q[i] <= '0;
      end
    end else if (w_push) begin
      r_data_q[r_wr_ptr] <= i_mem_rdata;
      r_addr_q[r_wr_ptr] <= r_req_addr;
    end
  end

  assign o_mem_req     = w_issue;
  assign o_mem_addr    = r_fpc;
  assign o_instr       = r_data_q[r_rd_ptr];
  assign o_instr_addr  = r_addr_q[r_rd_ptr];
  assign o_instr_valid = (r_count != '0);
  assign o_count       = r_count;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Self-checking bench for instruction_prefetch_queue: a memory model answers each request,
// and a scoreboard of expected {addr, instr} entries is compared on every pop.
module tb_instruction_prefetch_queue;

  localparam int unsigned DEPTH      = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] i_mem_rdata;
  logic        i_mem_rvalid;
  logic [31:0] o_instr;
  logic [31:0] o_instr_addr;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic        i_flush;
  logic [31:0] i_flush_addr;
  logic [$clog2(DEPTH):0] o_count;

  always #5 clk = ~clk;

  instruction_prefetch_queue #(
    .DEPTH      (DEPTH),
    .RESET_ADDR (RESET_ADDR)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_rdata   (i_mem_rdata),
    .i_mem_rvalid  (i_mem_rvalid),
    .o_instr       (o_instr),
    .o_instr_addr  (o_instr_addr),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .i_flush       (i_flush),
    .i_flush_addr  (i_flush_addr),
    .o_count       (o_count)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_addr[$];
  logic [31:0] sb_data[$];
  logic [31:0] exp_fpc;
  bit          pend_valid = 0;
  bit          pend_drop = 0;
  bit          stale = 0;
  logic [31:0] pend_addr;
  logic [31:0] pend_exp;
  int          lat = 0;
  int          mem_lat = 1;
  int          n_req = 0;
  int          n_pop = 0;
  logic [31:0] last_req_addr = '0;
  logic [31:0] last_pop_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  // One clock cycle: drive inputs, observe at negedge, update models, return at posedge+1.
  task automatic step(input logic fl, input logic [31:0] fa, input logic rdy);
    bit pend_before;
    i_flush       = fl;
    i_flush_addr  = fa;
    i_instr_ready = rdy;
    i_mem_rvalid  = 1'b0;
    i_mem_rdata   = '0;
    if (stale) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hDEAD_BEEF;
      stale        = 0;
    end else if (pend_valid) begin
      if (lat > 0) lat--;
      if (lat == 0) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = mem_word(pend_addr);
      end
    end
    @(negedge clk);
    pend_before = pend_valid;
    check("count", 32'(o_count), 32'(sb_addr.size()));
    check("instr_valid", 32'(o_instr_valid), 32'(sb_addr.size() != 0));
    if (fl) check("req_on_flush", 32'(o_mem_req), 32'd0);
    if (o_instr_valid && rdy && !fl && sb_addr.size() != 0) begin
      check("instr_addr", o_instr_addr, sb_addr[0]);
      check("instr", o_instr, sb_data[0]);
      last_pop_addr = sb_addr[0];
      void'(sb_addr.pop_front());
      void'(sb_data.pop_front());
      n_pop++;
    end
    if (i_mem_rvalid && pend_valid) begin
      if (!pend_drop && !fl) begin
        sb_addr.push_back(pend_exp);
        sb_data.push_back(mem_word(pend_exp));
      end
      pend_valid = 0;
    end
    if (o_mem_req) begin
      check("one_in_flight", 32'(pend_before), 32'd0);
      check("mem_addr", o_mem_addr, exp_fpc);
      pend_valid    = 1;
      pend_drop     = 0;
      pend_addr     = o_mem_addr;
      pend_exp      = exp_fpc;
      lat           = mem_lat;
      last_req_addr = o_mem_addr;
      n_req++;
      exp_fpc = exp_fpc + 32'd1;
    end
    if (fl) begin
      sb_addr.delete();
      sb_data.delete();
      exp_fpc = fa;
      if (pend_valid) pend_drop = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, 32'(o_mem_req), 32'd0);
    check({tag, "_mem_addr"}, o_mem_addr, RESET_ADDR);
    check({tag, "_count"}, 32'(o_count), 32'd0);
    check({tag, "_valid"}, 32'(o_instr_valid), 32'd0);
    check({tag, "_instr"}, o_instr, 32'd0);
    check({tag, "_instr_addr"}, o_instr_addr, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          nr;
    int          np;
    bit          found;
    logic [31:0] a0;
    i_rst_n       = 1'b0;
    i_flush       = 1'b0;
    i_flush_addr  = '0;
    i_instr_ready = 1'b0;
    i_mem_rvalid  = 1'b0;
    i_mem_rdata   = '0;
    exp_fpc       = RESET_ADDR;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    i_rst_n = 1'b1;

    // Streaming with 1-cycle memory and an always-ready consumer.
    np = n_pop;
    repeat (20) step(1'b0, 32'h0, 1'b1);
    check("p1_progress", 32'((n_pop - np) >= 8), 32'd1);

    // Consumer stalled: queue fills to DEPTH and requests stop.
    step(1'b1, 32'h0, 1'b0);
    nr = n_req;
    repeat (14) step(1'b0, 32'h0, 1'b0);
    check("full_reqs", 32'(n_req - nr), 32'd4);
    check("full_last_addr", last_req_addr, 32'd3);
    check("full_count", 32'(o_count), 32'd4);
    check("full_no_req", 32'(o_mem_req), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check("pop_count", 32'(o_count), 32'd3);
    step(1'b0, 32'h0, 1'b0);
    check("refill_reqs", 32'(n_req - nr), 32'd5);
    check("refill_addr", last_req_addr, 32'd4);

    // Flush while waiting on addr 5 (2-cycle memory): response dropped, redirect to 0x20.
    mem_lat = 2;
    step(1'b1, 32'h0, 1'b1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (pend_valid && last_req_addr == 32'd5) found = 1;
    end
    check("wait5_found", 32'(found), 32'd1);
    step(1'b1, 32'h20, 1'b1);
    check("flush_count", 32'(o_count), 32'd0);
    nr = n_req;
    np = n_pop;
    for (int i = 0; i < 6 && n_req == nr; i++) step(1'b0, 32'h0, 1'b1);
    check("flush_req_addr", last_req_addr, 32'h20);
    for (int i = 0; i < 10 && n_pop == np; i++) step(1'b0, 32'h0, 1'b1);
    check("flush_pop_addr", last_pop_addr, 32'h20);

    // Flush coincident with a response and a pop.
    mem_lat = 1;
    step(1'b1, 32'h0, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 32'h0, 1'b0);
      if (pend_valid && sb_addr.size() >= 1) found = 1;
    end
    check("coinc_found", 32'(found), 32'd1);
    check("coinc_rvalid_next", 32'(lat), 32'd1);
    step(1'b1, 32'h40, 1'b1);
    check("coinc_count", 32'(o_count), 32'd0);
    nr = n_req;
    step(1'b0, 32'h0, 1'b0);
    check("coinc_idle_req", 32'(n_req - nr), 32'd1);
    check("coinc_req_addr", last_req_addr, 32'h40);

    // Fetch pointer wraps from FFFFFFFF to 0.
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    nr = n_req;
    a0 = '1;
    for (int i = 0; i < 10 && (n_req - nr) < 2; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if ((n_req - nr) == 1) a0 = last_req_addr;
    end
    check("wrap_first", a0, 32'hFFFF_FFFF);
    check("wrap_second", last_req_addr, 32'h0);

    // Asynchronous reset while a fetch is in flight, then a stale response.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 32'h0, 1'b1);
      if (pend_valid) found = 1;
    end
    check("rst_wait_found", 32'(found), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb_addr.delete();
    sb_data.delete();
    pend_valid = 0;
    exp_fpc    = RESET_ADDR;
    stale      = 1;
    i_flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    nr = n_req;
    np = n_pop;
    step(1'b0, 32'h0, 1'b1);
    check("post_rst_req", 32'(n_req - nr), 32'd1);
    check("post_rst_addr", last_req_addr, RESET_ADDR);
    for (int i = 0; i < 8 && n_pop == np; i++) step(1'b0, 32'h0, 1'b1);
    check("post_rst_pop", last_pop_addr, RESET_ADDR);
    check("post_rst_popped", 32'(n_pop > np), 32'd1);
    repeat (6) step(1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
